// File: rtl/las_ctrl_pkg.sv
// rtl/las_ctrl_pkg.sv - shared states, control-word layout and encodings for the load/add/sub controller
package las_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    OPC_NONE = 2'd0,
    OPC_LW   = 2'd1,
    OPC_ADD  = 2'd2,
    OPC_SUB  = 2'd3
  } op_class_t;

  localparam int CW_W            = 18;
  localparam int CW_PC_WE        = 0;
  localparam int CW_IR_WE        = 1;
  localparam int CW_IORD         = 2;
  localparam int CW_MEM_WE       = 3;
  localparam int CW_REG_WE       = 4;
  localparam int CW_REGDST       = 5;
  localparam int CW_MEMTOREG     = 6;
  localparam int CW_ALUSRC_A     = 7;
  localparam int CW_ALUSRC_B_LSB = 8;
  localparam int CW_ALU_OP_LSB   = 10;
  localparam int CW_MDR_WE       = 13;
  localparam int CW_AB_WE        = 14;
  localparam int CW_ALUOUT_WE    = 15;
  localparam int CW_PCSRC        = 16;
  localparam int CW_WB_SEL       = 17;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [5:0] LAS_OP_LW    = 6'h23;
  localparam logic [5:0] LAS_OP_RTYPE = 6'h00;
  localparam logic [5:0] LAS_FN_ADD   = 6'h20;
  localparam logic [5:0] LAS_FN_SUB   = 6'h22;

endpackage

// File: rtl/las_ctrl_decode.sv
// rtl/las_ctrl_decode.sv - maps (next state, op class) to the 18-bit datapath control word
module las_ctrl_decode
  import las_ctrl_pkg::*;
(
  input  state_t          nstate_i,
  input  op_class_t       class_i,
  output logic [CW_W-1:0] ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (nstate_i)
      ST_FETCH: begin
        ctrl_o[CW_PC_WE]                = 1'b1;
        ctrl_o[CW_IR_WE]                = 1'b1;
        ctrl_o[CW_ALUSRC_B_LSB +: 2]    = SRCB_FOUR;
        ctrl_o[CW_ALU_OP_LSB +: 3]      = ALU_ADD;
      end
      ST_DECODE: begin
        ctrl_o[CW_AB_WE]                = 1'b1;
      end
      ST_MEMADR: begin
        ctrl_o[CW_ALUSRC_A]             = 1'b1;
        ctrl_o[CW_ALUSRC_B_LSB +: 2]    = SRCB_IMM;
        ctrl_o[CW_ALU_OP_LSB +: 3]      = ALU_ADD;
        ctrl_o[CW_ALUOUT_WE]            = 1'b1;
      end
      ST_MEMRD: begin
        ctrl_o[CW_IORD]                 = 1'b1;
        ctrl_o[CW_MDR_WE]               = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o[CW_REG_WE]               = 1'b1;
        ctrl_o[CW_MEMTOREG]             = 1'b1;
        ctrl_o[CW_WB_SEL]               = 1'b1;
      end
      ST_EXEC: begin
        // ALU operation comes from the class latched in DECODE, never the live funct
        ctrl_o[CW_ALUSRC_A]             = 1'b1;
        ctrl_o[CW_ALUSRC_B_LSB +: 2]    = SRCB_REG;
        ctrl_o[CW_ALU_OP_LSB +: 3]      = (class_i == OPC_SUB) ? ALU_SUB : ALU_ADD;
        ctrl_o[CW_ALUOUT_WE]            = 1'b1;
      end
      ST_ALUWB: begin
        ctrl_o[CW_REG_WE]               = 1'b1;
        ctrl_o[CW_REGDST]               = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/las_multicycle_ctrl.sv
// rtl/las_multicycle_ctrl.sv - multicycle LW/ADD/SUB control FSM with registered control word and retire counter
module las_multicycle_ctrl
  import las_ctrl_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [5:0] OP_LW    = LAS_OP_LW,
  parameter logic [5:0] OP_RTYPE = LAS_OP_RTYPE,
  parameter logic [5:0] FN_ADD   = LAS_FN_ADD,
  parameter logic [5:0] FN_SUB   = LAS_FN_SUB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [CW_W-1:0]  ctrl_word,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_o
);

  state_t           state_q, state_d;
  op_class_t        class_q, class_d, decoded;
  logic [CW_W-1:0]  ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    decoded = OPC_NONE;
    if (opcode == OP_LW)                            decoded = OPC_LW;
    else if (opcode == OP_RTYPE && funct == FN_ADD) decoded = OPC_ADD;
    else if (opcode == OP_RTYPE && funct == FN_SUB) decoded = OPC_SUB;
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = decoded;
        case (decoded)
          OPC_LW:           state_d = ST_MEMADR;
          OPC_ADD, OPC_SUB: state_d = ST_EXEC;
          default:          state_d = ST_IDLE;
        endcase
      end
      ST_MEMADR: state_d = ST_MEMRD;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_MEMWB, ST_ALUWB: state_d = start ? ST_FETCH : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  las_ctrl_decode u_decode (
    .nstate_i (state_d),
    .class_i  (class_d),
    .ctrl_o   (ctrl_d)
  );

  // Pulses and the counter are registered alongside the state so they line up with the final state
  always_comb begin
    done_d    = (state_d == ST_MEMWB) || (state_d == ST_ALUWB);
    illegal_d = (state_q == ST_DECODE) && (decoded == OPC_NONE);
    cnt_d     = done_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      class_q   <= OPC_NONE;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ctrl_word   = ctrl_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;
  assign state_o     = state_q;

endmodule
